// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load writeback paths.
// A one-entry write stage drives WE3/A3/WD3 and supplies read-after-write bypass for the two read ports.
module rf_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          byp1_hit,
  output logic [DW-1:0] byp1_data,
  output logic          byp2_hit,
  output logic [DW-1:0] byp2_data
);

  logic          rr_ptr_r;
  logic          stage_valid_r;
  logic [AW-1:0] rf_addr_r;
  logic [DW-1:0] rf_wdata_r;

  logic          grant0_s;
  logic          grant1_s;
  logic          hs_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_data_s;

  // Grant selection; readys are held low while reset is asserted.
  always_comb begin
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    win_addr_s = req0_addr;
    win_data_s = req0_data;
    if (areset) begin
      grant0_s = req0_valid & (~req1_valid | ~rr_ptr_r);
      grant1_s = req1_valid & (~req0_valid |  rr_ptr_r);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    if (grant1_s) begin
      win_addr_s = req1_addr;
      win_data_s = req1_data;
    end else begin
      win_addr_s = req0_addr;
      win_data_s = req0_data;
    end
  end

  assign hs_s       = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Write stage and round-robin pointer; the stage drains every cycle.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rr_ptr_r      <= 1'b0;
      stage_valid_r <= 1'b0;
      rf_addr_r     <= {AW{1'b0}};
      rf_wdata_r    <= {DW{1'b0}};
    end else if (hs_s) begin
      // x0 writes are consumed but never reach the RF.
      stage_valid_r <= (win_addr_s != {AW{1'b0}});
      rf_addr_r     <= win_addr_s;
      rf_wdata_r    <= win_data_s;
      rr_ptr_r      <= ~grant1_s;
    end else begin
      stage_valid_r <= 1'b0;
    end
  end

  assign rf_we    = stage_valid_r;
  assign rf_addr  = rf_addr_r;
  assign rf_wdata = rf_wdata_r;

  assign byp1_hit  = stage_valid_r & (rf_addr_r == rd_a1) & (rd_a1 != {AW{1'b0}});
  assign byp2_hit  = stage_valid_r & (rf_addr_r == rd_a2) & (rd_a2 != {AW{1'b0}});
  assign byp1_data = rf_wdata_r;
  assign byp2_data = rf_wdata_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          areset;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rd_a1;
  logic [AW-1:0] rd_a2;
  logic          byp1_hit;
  logic [DW-1:0] byp1_data;
  logic          byp2_hit;
  logic [DW-1:0] byp2_data;

  int vec_cnt = 0;
  int miss_cnt = 0;

  rf_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .areset(areset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rd_a1(rd_a1), .rd_a2(rd_a2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data), .byp2_hit(byp2_hit), .byp2_data(byp2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset     = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0000_00AA;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h0000_00BB;
    rd_a1      = 5'd0; rd_a2 = 5'd0;

    // 1: reset with both valids high
    #1;
    check_vec("rst_we",     {31'd0, rf_we},      32'd0);
    check_vec("rst_rdy0",   {31'd0, req0_ready}, 32'd0);
    check_vec("rst_rdy1",   {31'd0, req1_ready}, 32'd0);
    check_vec("rst_addr",   {27'd0, rf_addr},    32'd0);
    check_vec("rst_wdata",  rf_wdata,            32'd0);
    tick(); tick();
    check_vec("rst_we2",    {31'd0, rf_we},      32'd0);
    check_vec("rst_rdy0_2", {31'd0, req0_ready}, 32'd0);
    areset = 1'b1;
    #1;
    check_vec("rel_rdy0",   {31'd0, req0_ready}, 32'd1);
    check_vec("rel_rdy1",   {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check_vec("rel_we",     {31'd0, rf_we},      32'd1);
    check_vec("rel_addr",   {27'd0, rf_addr},    32'd10);
    check_vec("rel_wdata",  rf_wdata,            32'h0000_00AA);
    check_vec("rel_rdy1b",  {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check_vec("rel_addr2",  {27'd0, rf_addr},    32'd11);
    check_vec("rel_wdata2", rf_wdata,            32'h0000_00BB);
    tick();
    check_vec("idle_we",    {31'd0, rf_we},      32'd0);
    check_vec("idle_addr",  {27'd0, rf_addr},    32'd11);
    check_vec("idle_wdata", rf_wdata,            32'h0000_00BB);

    // 2: single request on req0
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    check_vec("sgl_rdy0", {31'd0, req0_ready}, 32'd1);
    check_vec("sgl_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check_vec("sgl_we",    {31'd0, rf_we},   32'd1);
    check_vec("sgl_addr",  {27'd0, rf_addr}, 32'd5);
    check_vec("sgl_wdata", rf_wdata,         32'hDEAD_BEEF);

    // 4: x0 request on req1 (also moves the pointer back to req0)
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    check_vec("x0_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check_vec("x0_we",   {31'd0, rf_we},    32'd0);
    check_vec("x0_byp1", {31'd0, byp1_hit}, 32'd0);
    check_vec("x0_byp2", {31'd0, byp2_hit}, 32'd0);

    // 3: contention, expect strict alternation starting with req0
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0111;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0222;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_vec($sformatf("cont_rdy0_%0d", i), {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_vec($sformatf("cont_rdy1_%0d", i), {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check_vec($sformatf("cont_addr_%0d", i), {27'd0, rf_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check_vec($sformatf("cont_we_%0d", i),   {31'd0, rf_we},   32'd1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 5: bypass
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5_A5A5;
    tick();
    req0_valid = 1'b0;
    rd_a1 = 5'd7; rd_a2 = 5'd3;
    #1;
    check_vec("byp1_hit",  {31'd0, byp1_hit}, 32'd1);
    check_vec("byp1_data", byp1_data,         32'hA5A5_A5A5);
    check_vec("byp2_miss", {31'd0, byp2_hit}, 32'd0);
    rd_a2 = 5'd7;
    #1;
    check_vec("byp2_hit",  {31'd0, byp2_hit}, 32'd1);
    tick();
    check_vec("byp1_gone", {31'd0, byp1_hit}, 32'd0);
    rd_a1 = 5'd0; rd_a2 = 5'd0;

    // same destination from both: pointer favours req1 now, req0 writes last
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0001;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_0002;
    #1;
    check_vec("same_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    check_vec("same_w1", rf_wdata, 32'h0000_0002);
    tick();
    req0_valid = 1'b0;
    check_vec("same_w2", rf_wdata, 32'h0000_0001);
    check_vec("same_a2", {27'd0, rf_addr}, 32'd9);

    // 6: reset mid-operation
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h0000_CAFE;
    tick();
    req0_valid = 1'b0;
    check_vec("mid_we_pre", {31'd0, rf_we}, 32'd1);
    areset = 1'b0;
    #1;
    check_vec("mid_we",   {31'd0, rf_we},   32'd0);
    check_vec("mid_addr", {27'd0, rf_addr}, 32'd0);
    req0_valid = 1'b1; req0_addr = 5'd13; req0_data = 32'h0000_0013;
    req1_valid = 1'b1; req1_addr = 5'd14; req1_data = 32'h0000_0014;
    tick();
    check_vec("mid_we_rst", {31'd0, rf_we}, 32'd0);
    areset = 1'b1;
    #1;
    check_vec("mid_rdy0", {31'd0, req0_ready}, 32'd1);
    check_vec("mid_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    check_vec("mid_addr2", {27'd0, rf_addr}, 32'd13);
    tick();
    req1_valid = 1'b0;
    check_vec("mid_addr3", {27'd0, rf_addr}, 32'd14);
    tick();
    check_vec("mid_idle", {31'd0, rf_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
